// File: rtl/alu_pkg.sv
// Shared opcode map, operand limits and sequencer state encoding for the ALU front end.
package alu_pkg;

  localparam logic [5:0] OP_CLR      = 6'd0;
  localparam logic [5:0] OP_PASS_A   = 6'd1;
  localparam logic [5:0] OP_PASS_B   = 6'd2;
  localparam logic [5:0] OP_NEG_A    = 6'd3;
  localparam logic [5:0] OP_FACT     = 6'd4;
  localparam logic [5:0] OP_EXP      = 6'd5;
  localparam logic [5:0] OP_ADD      = 6'd6;
  localparam logic [5:0] OP_SUB      = 6'd7;
  localparam logic [5:0] OP_MUL      = 6'd8;
  localparam logic [5:0] OP_DIV      = 6'd9;
  localparam logic [5:0] OP_AND      = 6'd10;
  localparam logic [5:0] OP_OR       = 6'd11;
  localparam logic [5:0] OP_XOR      = 6'd12;
  localparam logic [5:0] OP_NOT_ACC  = 6'd13;
  localparam logic [5:0] OP_INC_ACC  = 6'd14;
  localparam logic [5:0] OP_DEC_ACC  = 6'd15;
  localparam logic [5:0] OP_FACT_ACC = 6'd16;
  localparam logic [5:0] OP_EXP_ACC  = 6'd17;
  localparam logic [5:0] OP_ADD_ACC  = 6'd18;
  localparam logic [5:0] OP_SUB_ACC  = 6'd19;
  localparam logic [5:0] OP_MUL_ACC  = 6'd20;
  localparam logic [5:0] OP_DIV_ACC  = 6'd21;
  localparam logic [5:0] OP_AND_ACC  = 6'd22;
  localparam logic [5:0] OP_OR_ACC   = 6'd23;
  localparam logic [5:0] OP_XOR_ACC  = 6'd24;
  localparam logic [5:0] OP_MAX      = OP_XOR_ACC;

  // Largest operands whose factorial / exponential still fit the 32-bit result.
  localparam int FACT_LIMIT = 12;
  localparam int EXP_LIMIT  = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Registered command FIFO: an entry written at one edge is readable after it.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 38
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the accumulator ALU: queues commands, screens illegal
// opcodes/operands, drives the ALU, owns the accumulator and returns responses.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting; pops and classifies the next queued command
//   ST_EXEC | ALU inputs driven, down-counter runs to alu_out sample
//   ST_RESP | response presented, held until rsp_ready
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int W     = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [5:0]     cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_err,
  output logic [W-1:0]   rsp_acc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [W-1:0]   alu_acc,
  output logic [5:0]     alu_sel,
  input  logic [2*W-1:0] alu_out,
  output logic           busy
);

  localparam int FW = 6 + 2 * W;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [W-1:0] FACT_LIM = W'(FACT_LIMIT);
  localparam logic [W-1:0] EXP_LIM  = W'(EXP_LIMIT);

  seq_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [5:0]     sel_q, sel_d;
  logic [2*W-1:0] res_q, res_d;
  logic           err_q, err_d;

  logic           fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]  fifo_rd;
  logic [5:0]     f_op;
  logic [W-1:0]   f_a, f_b;
  logic           range_err;

  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(FW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .wr_data ({cmd_op, cmd_a, cmd_b}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {f_op, f_a, f_b} = fifo_rd;

  // Operands the ALU cannot represent: divide by zero, factorial/exp overflow.
  assign range_err = ((f_op == OP_DIV || f_op == OP_DIV_ACC) && f_b == '0)
                  || (f_op == OP_FACT     && f_a   > FACT_LIM)
                  || (f_op == OP_FACT_ACC && acc_q > FACT_LIM)
                  || (f_op == OP_EXP      && f_a   > EXP_LIM)
                  || (f_op == OP_EXP_ACC  && acc_q > EXP_LIM);

  assign cmd_ready  = !fifo_full;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign rsp_acc    = acc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_acc    = acc_q;
  assign alu_sel    = sel_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    res_d    = res_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_RESP;
          res_d    = '0;
          if (f_op == OP_CLR) begin
            acc_d = '0;
            a_d   = '0;
            b_d   = '0;
            sel_d = OP_CLR;
            err_d = 1'b0;
          end else if (f_op > OP_MAX || range_err) begin
            err_d = 1'b1;
          end else begin
            a_d     = f_a;
            b_d     = f_b;
            sel_d   = f_op;
            cnt_d   = CW'(LAT - 1);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_out;
          acc_d   = alu_out[W-1:0];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter, accumulator, ALU operand and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, vector table and scoreboard.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int W     = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [5:0]    cmd_op;
  logic [15:0]   cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0]   rsp_result, alu_out;
  logic [15:0]   rsp_acc, alu_a, alu_b, alu_acc;
  logic [5:0]    alu_sel;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        err;
    logic [15:0] acc;
    logic [5:0]  sel;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [15:0] acc;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .LAT(LAT), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_acc(rsp_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc), .alu_sel(alu_sel),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [15:0] n);
    logic [31:0] r;
    r = 32'd1;
    if (n > 16'd12) return 32'd0;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Behavioural stand-in for the ALU (only the opcodes exercised here).
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      6'd4:  alu_out = fact(alu_a);
      6'd6:  alu_out = 32'(alu_a) + 32'(alu_b);
      6'd7:  alu_out = {16'h0, alu_a - alu_b};
      6'd8:  alu_out = 32'(alu_a) * 32'(alu_b);
      6'd9:  alu_out = (alu_b != 16'd0) ? {16'h0, alu_a / alu_b} : 32'd0;
      6'd10: alu_out = {16'h0, alu_a & alu_b};
      6'd13: alu_out = {16'h0, ~alu_acc};
      6'd16: alu_out = fact(alu_acc);
      6'd18: alu_out = 32'(alu_acc) + 32'(alu_b);
      6'd24: alu_out = {16'h0, alu_acc ^ alu_b};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each response in the cycle before it transfers.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result 0x%0h with no command outstanding", rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_acc", rsp_acc, e.acc);
      end
    end
  end

  task automatic offer(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                       output bit ok);
    bit r;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok, r;
    int lat, n, hi;

    tbl[0]  = '{6'd6,  16'd3,      16'd4,      32'd7,         1'b0, 16'd7,      6'd6};
    tbl[1]  = '{6'd18, 16'd0,      16'd5,      32'd12,        1'b0, 16'd12,     6'd18};
    tbl[2]  = '{6'd16, 16'd0,      16'd0,      32'h1C8CFC00,  1'b0, 16'hFC00,   6'd16};
    tbl[3]  = '{6'd9,  16'd10,     16'd0,      32'd0,         1'b1, 16'hFC00,   6'd16};
    tbl[4]  = '{6'd30, 16'd1,      16'd1,      32'd0,         1'b1, 16'hFC00,   6'd16};
    tbl[5]  = '{6'd0,  16'd7,      16'd7,      32'd0,         1'b0, 16'd0,      6'd0};
    tbl[6]  = '{6'd13, 16'd0,      16'd0,      32'h0000FFFF,  1'b0, 16'hFFFF,   6'd13};
    tbl[7]  = '{6'd7,  16'd5,      16'd7,      32'h0000FFFE,  1'b0, 16'hFFFE,   6'd7};
    tbl[8]  = '{6'd4,  16'd13,     16'd0,      32'd0,         1'b1, 16'hFFFE,   6'd7};
    tbl[9]  = '{6'd16, 16'd0,      16'd0,      32'd0,         1'b1, 16'hFFFE,   6'd7};
    tbl[10] = '{6'd17, 16'd0,      16'd0,      32'd0,         1'b1, 16'hFFFE,   6'd7};
    tbl[11] = '{6'd5,  16'd23,     16'd0,      32'd0,         1'b1, 16'hFFFE,   6'd7};
    tbl[12] = '{6'd0,  16'd0,      16'd0,      32'd0,         1'b0, 16'd0,      6'd0};
    tbl[13] = '{6'd21, 16'd5,      16'd0,      32'd0,         1'b1, 16'd0,      6'd0};
    tbl[14] = '{6'd8,  16'h1234,   16'h0100,   32'h00123400,  1'b0, 16'h3400,   6'd8};
    tbl[15] = '{6'd10, 16'hF0F0,   16'h0FF0,   32'h000000F0,  1'b0, 16'h00F0,   6'd10};
    tbl[16] = '{6'd25, 16'd1,      16'd1,      32'd0,         1'b1, 16'h00F0,   6'd10};
    tbl[17] = '{6'd24, 16'd0,      16'h0F0F,   32'h00000FFF,  1'b0, 16'h0FFF,   6'd24};
    tbl[18] = '{6'd4,  16'd12,     16'd0,      32'h1C8CFC00,  1'b0, 16'hFC00,   6'd4};
    tbl[19] = '{6'd9,  16'd100,    16'd7,      32'd14,        1'b0, 16'd14,     6'd9};

    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_sel", alu_sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_acc", rsp_acc, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;

    // One command at a time: latency, response contents, selector afterwards.
    for (int i = 0; i < 20; i++) begin
      sb.push_back('{res: tbl[i].res, err: tbl[i].err, acc: tbl[i].acc});
      offer(tbl[i].op, tbl[i].a, tbl[i].b, ok);
      chk("accept", ok, 1);
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        lat++;
        if (rsp_valid) break;
      end
      chk("latency", lat, (tbl[i].err || tbl[i].op == 6'd0) ? 1 : LAT + 1);
      @(posedge clk);
      #1;
      chk("alu_sel_after", alu_sel, tbl[i].sel);
      chk("rsp_valid_drop", rsp_valid, 0);
    end

    // Backpressure: one command in the FSM plus DEPTH queued, then full.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 6'd6;
      cmd_a = 16'(10 * i);
      cmd_b = 16'd1;
      @(negedge clk);
      r = cmd_ready;
      chk("bp_ready", r, (i < 5) ? 1 : 0);
      @(posedge clk);
      #1;
      if (r) sb.push_back('{res: 32'(10 * i + 1), err: 1'b0, acc: 16'(10 * i + 1)});
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_full", cmd_ready, 0);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 32'd1);
      chk("bp_hold_acc", rsp_acc, 16'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      n++;
      if (r) break;
    end
    cmd_valid = 1'b0;
    chk("bp_sixth_accept_edge", n, 3);
    sb.push_back('{res: 32'd51, err: 1'b0, acc: 16'd51});
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("bp_drained", sb.size(), 0);

    // Reset during EXEC with a second command queued behind it.
    cmd_valid = 1'b1;
    cmd_op = 6'd6;
    cmd_a = 16'd1;
    cmd_b = 16'd1;
    @(negedge clk);
    chk("rst_first_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_a = 16'd2;
    @(negedge clk);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rst_in_exec_sel", alu_sel, 6'd6);
    chk("rst_in_exec_busy", busy, 1);
    chk("rst_in_exec_acc", alu_acc, 16'd51);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_alu_sel", alu_sel, 0);
    chk("rst_async_acc", alu_acc, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_after_ready", cmd_ready, 1);
    chk("rst_after_busy", busy, 0);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) hi++;
    end
    chk("rst_no_stale_rsp", hi, 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-issuing front end for the 16-bit accumulator ALU. It accepts opcode/operand commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's a, b, acc and sel inputs, samples the ALU's 32-bit result and owns the accumulator register. Each command returns one in-order response with an error flag. It replaces the hand-stepped selector stimulus and the operand/accumulator flops around the ALU.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
LAT, 1, cycles from ALU inputs being driven to alu_out being sampled (>=1)
W, 16, operand and accumulator width

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  6  opcode, 0..24 per ALU opcode map
cmd_a  in  W  operand A
cmd_b  in  W  operand B
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_result  out  2W  result
rsp_err  out  1  command rejected (illegal opcode or out-of-range operand)
rsp_acc  out  W  accumulator value after this command
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_acc  out  W  to ALU acc (the accumulator register)
alu_sel  out  6  to ALU sel
alu_out  in  2W  from ALU out
busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, reset_n=0): FIFO emptied, FSM=IDLE, all outputs 0. After reset, cmd_ready=1 and alu_sel=0.
- Handshakes: a command is pushed when cmd_valid&cmd_ready at a clk edge. cmd_ready=!full; no push while full, even if a pop occurs in the same cycle. A response transfers on rsp_valid&rsp_ready.
- rsp_valid, rsp_result, rsp_err and rsp_acc are held stable until the response transfers.
- FIFO is registered (not fall-through). An entry pushed at edge k is poppable at edge k+1.
- FSM states: IDLE, EXEC, RESP.
- IDLE, FIFO empty: hold all ALU outputs.
- IDLE, FIFO non-empty: pop at the edge, then classify:
  - op=0 (clear): acc<=0; alu_a, alu_b, alu_sel<=0; result=0, err=0; go to RESP.
  - op>24: err=1, result=0; acc and ALU outputs unchanged; go to RESP.
  - Range error: (op==9 or op==21) with b==0; op==4 with a>12; op==16 with acc>12; op==5 with a>22; op==17 with acc>22. Action: err=1, result=0; acc and ALU outputs unchanged; go to RESP.
  - Otherwise: alu_a<=a, alu_b<=b, alu_sel<=op, wait counter<=LAT-1; go to EXEC.
- EXEC: counter decrements each cycle. At the edge where counter==0: rsp_result<=alu_out, acc<=alu_out[W-1:0], err=0; go to RESP.
- RESP: rsp_valid=1 and rsp_acc=acc. On transfer, go to IDLE. The next pop can occur at the following edge.
- Latency, empty FIFO and rsp_ready=1: cmd accepted at edge 0, popped at edge 1, result captured at edge 1+LAT, response transfers at edge 2+LAT. Throughput: one command per LAT+2 cycles.
- Arithmetic: no internal arithmetic beyond range checks (unsigned). Subtract wrap-around passes through unflagged. The accumulator takes only the low W bits of 2W results.
- Reset mid-operation: an in-flight command and any queued commands are discarded with no response. acc=0.

Decomposition:
- Shared package alu_pkg: opcode constants OP_CLR..OP_XOR_ACC (0..24), OP_MAX=24, FACT_LIMIT=12, EXP_LIMIT=22, FSM state encoding.
- One sub-module: alu_cmd_fifo (DEPTH x (6+2W)). Synchronous push/pop, async active-low reset, full/empty flags.

Test Plan:
1. Reset, then op=6 a=3 b=4 with rsp_ready=1 -> rsp_result=7, err=0, rsp_acc=7; rsp_valid seen 2 edges after accept (LAT=1).
2. Following op=18 b=5 -> result=12, acc=12. Then op=16 -> result=0x1C8CFC00, acc=0xFC00, err=0.
3. op=9 a=10 b=0 -> err=1, result=0, acc unchanged, alu_sel unchanged. Then op=30 -> err=1, result=0.
4. op=0 after any command -> result=0, acc=0, alu_sel=0. Next op=13 -> result=0xFFFF, acc=0xFFFF.
5. rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 in FSM + 4 in FIFO), cmd_ready=0 from the 6th. Raise rsp_ready -> responses in order, 6th accepted one cycle after the first pop.
6. reset_n low during EXEC -> rsp_valid, alu_sel, acc go 0 immediately without a clock edge. After release: cmd_ready=1, busy=0, no stale response emitted.
